// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between one master and the word-addressed memory responder.
// hready is the bus-level ready; hreadyout is the responder's own ready.
interface ahb_slave_mem_if;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, htrans, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, htrans, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder over a word-addressed memory with programmable wait states and ERROR.
// Optional AHB_SLAVE_SEQ_NOWAIT_EN: accepted SEQ beats skip the wait states.
module ahb_slave_mem #(
  parameter logic [1:0] SLAVE_ID    = 2'b01,
  parameter int         DEPTH       = 256,
  parameter int         WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           hresetn,
  ahb_slave_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state_q;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [3:0]    cnt_q;
  logic          hreadyout_q;
  logic          hresp_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          illegal;
  logic          need_wait;
  logic          commit;
  logic [3:0]    commit_be;
  logic [AW-1:0] new_idx;
  logic [AW-1:0] cur_idx;
  logic [31:0]   fwd_word;
  logic          unused_bits;

  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    lane_be = 4'b0001 << lo;
      3'd1:    lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  always_comb begin
    accept  = (state_q inside {S_IDLE, S_DATA, S_ERR2}) && (bus.hsel == SLAVE_ID) &&
              bus.hready && bus.htrans[1];
    illegal = (bus.hsize > 3'd2) ||
              (bus.hsize == 3'd1 && bus.haddr[0]) ||
              (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00) ||
              (bus.haddr[31:AW+2] != '0);
`ifdef AHB_SLAVE_SEQ_NOWAIT_EN
    need_wait = (WAIT_STATES > 0) && (bus.htrans != 2'b11);
`else
    need_wait = (WAIT_STATES > 0);
`endif
    new_idx   = bus.haddr[AW+1:2];
    cur_idx   = addr_q[AW+1:2];
    commit    = (state_q == S_DATA) && write_q;
    commit_be = lane_be(size_q, addr_q[1:0]);
  end

  // A zero-wait read accepted while a write to the same word commits must see the new bytes.
  always_comb begin
    fwd_word = mem_q[new_idx];
    if (commit && cur_idx == new_idx) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_be[i]) fwd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            if (!write_q) hrdata_q <= mem_q[cur_idx];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr_q  <= bus.haddr[AW+1:0];
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
            if (illegal) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (need_wait) begin
              state_q     <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
              cnt_q       <= 4'(WAIT_STATES - 1);
            end else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              if (!bus.hwrite) hrdata_q <= fwd_word;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage is deliberately left unreset; a reset edge still blocks the pending commit.
  always_ff @(posedge clk) begin
    if (hresetn && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_be[i]) mem_q[cur_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign unused_bits   = ^{bus.hburst, bus.htrans[0]};
endmodule
